det5_matrix_loader: RTL and testbench

Sequencer that sits directly upstream of the 5x5 determinant stage. It accepts matrix elements one byte per beat over a valid/ready stream and packs them row-major into the flattened 200-bit matrix bus. It holds that bus stable for a programmable settle window so the combinational determinant tree can resolve. It then latches the determinant and overflow and presents them on a valid/ready result port.

---
 rtl/det5_matrix_loader_pkg.sv | 21 ++
 rtl/det5_matrix_loader_settle_timer.sv | 38 +++
 rtl/det5_matrix_loader.sv | 129 ++++++++++++
 tb/tb_det5_matrix_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/det5_matrix_loader_pkg.sv
// Shared definitions for the 5x5 determinant loader: geometry, FSM encoding
// and the row-major slot mapping of the flattened matrix bus.
package det5_matrix_loader_pkg;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;
  localparam int MW = NE * W;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_e;

  // LSB position of element k; element 0 sits in the top byte of the bus.
  function automatic logic [7:0] slot_lsb(input logic [4:0] k);
    slot_lsb = 8'(MW - W - W * int'(k));
  endfunction

endpackage

// File: rtl/det5_matrix_loader_settle_timer.sv
// Loadable down-counter with a zero flag; saturates at zero so it can be left
// decrementing while the owner waits on the flag.
module det5_settle_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {CW{1'b0}})) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {CW{1'b0}});

endmodule

// File: rtl/det5_matrix_loader.sv
// Streams 25 bytes row-major onto the determinant stage's matrix bus, holds the
// bus for a settle window, then returns the latched determinant over valid/ready.
module det5_matrix_loader
  import det5_matrix_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic [MW-1:0] matrix,
  input  logic [W-1:0]  det_in,
  input  logic          ovf_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_det,
  output logic          res_ovf,
  output logic          busy,
  output logic          err
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [4:0] IDX_LAST = 5'(NE - 1);

  state_e        state_q;
  logic [4:0]    idx_q;
  logic [MW-1:0] matrix_q;
  logic          in_ready_q;
  logic          res_valid_q;
  logic [W-1:0]  res_det_q;
  logic          res_ovf_q;
  logic          busy_q;
  logic          err_q;

  logic xfer_s;
  logic timer_load_s;
  logic timer_dec_s;
  logic timer_zero_s;

  assign xfer_s       = in_valid && in_ready_q && (state_q == LOAD);
  assign timer_load_s = xfer_s && (idx_q == IDX_LAST);
  assign timer_dec_s  = (state_q == SETTLE);

  det5_settle_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load_s),
    .load_val_i (CW'(SETTLE_CYCLES - 1)),
    .dec_i      (timer_dec_s),
    .zero_o     (timer_zero_s)
  );

  // Sequencer: every output is registered and updated together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= 5'd0;
      matrix_q    <= {MW{1'b0}};
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_det_q   <= {W{1'b0}};
      res_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (xfer_s) begin
            if (idx_q == IDX_LAST) begin
              // A full matrix without in_last is still used, but flagged.
              matrix_q[slot_lsb(idx_q) +: W] <= in_data;
              idx_q      <= 5'd0;
              err_q      <= ~in_last;
              state_q    <= SETTLE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else if (in_last) begin
              matrix_q <= {MW{1'b0}};
              idx_q    <= 5'd0;
              err_q    <= 1'b1;
            end else begin
              matrix_q[slot_lsb(idx_q) +: W] <= in_data;
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        SETTLE: begin
          if (timer_zero_s) begin
            res_det_q   <= det_in;
            res_ovf_q   <= ovf_in;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            matrix_q    <= {MW{1'b0}};
            state_q     <= LOAD;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOAD;
          idx_q       <= 5'd0;
          matrix_q    <= {MW{1'b0}};
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign matrix    = matrix_q;
  assign res_valid = res_valid_q;
  assign res_det   = res_det_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_det5_matrix_loader.sv
// Directed-sequence bench with random element data checked against a queue-based
// model of the current frame.
module tb_det5_matrix_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic [199:0] matrix;
  logic [7:0]   det_in;
  logic         ovf_in;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_det;
  logic         res_ovf;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] elem [25];
  logic [7:0] frame_q [$];

  det5_matrix_loader #(.SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .matrix    (matrix),
    .det_in    (det_in),
    .ovf_in    (ovf_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_det   (res_det),
    .res_ovf   (res_ovf),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus image of the accepted elements: first element in the top byte, rest zero.
  function automatic logic [199:0] model_matrix();
    logic [199:0] m = '0;
    for (int k = 0; k < 25; k++) begin
      m = m << 8;
      if (k < frame_q.size()) m[7:0] = frame_q[k];
    end
    return m;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic last);
    int guard = 0;
    logic exp_err;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("ready_timeout", {199'd0, in_ready}, 200'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last && frame_q.size() < 24) begin
      frame_q.delete();
      exp_err = 1'b1;
    end else begin
      frame_q.push_back(d);
      exp_err = (frame_q.size() == 25) && !last;
    end
    check("err_after_beat", {199'd0, err}, {199'd0, exp_err});
    check("matrix_after_beat", matrix, model_matrix());
  endtask

  task automatic stream(input int nbeats, input int last_k, input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && k > 0) tick();
      send_beat(elem[k], k == last_k);
    end
  endtask

  // Called right after the edge that took beat 25: result must appear on the
  // fifth cycle counted from the beat's own cycle.
  task automatic wait_result(input logic [7:0] exp_det, input logic exp_ovf);
    int lat = 1;
    check("ready_low_settle", {199'd0, in_ready}, 200'd0);
    check("busy_settle", {199'd0, busy}, 200'd1);
    while (res_valid !== 1'b1 && lat < 60) begin
      check("ready_low_wait", {199'd0, in_ready}, 200'd0);
      tick();
      lat++;
    end
    check("result_latency", 200'(lat), 200'd5);
    check("res_det", {192'd0, res_det}, {192'd0, exp_det});
    check("res_ovf", {199'd0, res_ovf}, {199'd0, exp_ovf});
    check("matrix_frozen", matrix, model_matrix());
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    frame_q.delete();
    check("valid_drop", {199'd0, res_valid}, 200'd0);
    check("ready_rise", {199'd0, in_ready}, 200'd1);
    check("matrix_cleared", matrix, 200'd0);
    check("busy_clear", {199'd0, busy}, 200'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_matrix"}, matrix, 200'd0);
    check({tag, "_outs"}, {192'd0, in_ready, res_valid, res_ovf, busy, err, 3'd0},
          200'd0);
    check({tag, "_det"}, {192'd0, res_det}, 200'd0);
  endtask

  task automatic randomize_elems();
    for (int k = 0; k < 25; k++) elem[k] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    det_in = 8'd0; ovf_in = 1'b0; res_ready = 1'b0;
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", {199'd0, in_ready}, 200'd1);

    // Identity matrix, determinant 1.
    for (int k = 0; k < 25; k++) elem[k] = (k % 6 == 0) ? 8'd1 : 8'd0;
    det_in = 8'd1; ovf_in = 1'b0;
    stream(25, 24, 1'b0);
    wait_result(8'd1, 1'b0);
    take_result();

    // Counting pattern with idle cycles between beats.
    for (int k = 0; k < 25; k++) elem[k] = 8'(k + 1);
    det_in = 8'hA5;
    stream(25, 24, 1'b1);
    check("first_slot", {192'd0, matrix[199:192]}, 200'd1);
    check("last_slot", {192'd0, matrix[7:0]}, 200'd25);
    wait_result(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ready_low_result", {199'd0, in_ready}, 200'd0);
    end
    take_result();

    // Early in_last on beat 10, then a clean random frame.
    randomize_elems();
    stream(10, 9, 1'b0);
    check("framing_matrix_zero", matrix, 200'd0);
    tick();
    check("err_one_cycle", {199'd0, err}, 200'd0);
    randomize_elems();
    d = 8'($urandom);
    det_in = d;
    stream(25, 24, 1'b0);
    wait_result(d, 1'b0);
    take_result();

    // Overflow result under 20 cycles of backpressure.
    randomize_elems();
    det_in = 8'd0; ovf_in = 1'b1;
    stream(25, 24, 1'b0);
    wait_result(8'd0, 1'b1);
    det_in = 8'h3C; ovf_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", {199'd0, res_valid}, 200'd1);
      check("bp_hold", {191'd0, res_ovf, res_det}, {191'd0, 1'b1, 8'd0});
      check("bp_ready", {199'd0, in_ready}, 200'd0);
    end
    take_result();

    // Asynchronous reset in the middle of SETTLE.
    randomize_elems();
    stream(25, 24, 1'b0);
    tick();
    tick();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    frame_q.delete();
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_result_after_rst", {199'd0, res_valid}, 200'd0);
    end
    randomize_elems();
    send_beat(elem[0], 1'b0);
    check("restart_slot0", {192'd0, matrix[199:192]}, {192'd0, elem[0]});
    for (int k = 1; k < 25; k++) send_beat(elem[k], k == 24);
    d = 8'($urandom);
    det_in = d;
    wait_result(d, 1'b0);
    take_result();

    // Beat 25 without in_last: flagged but still processed normally.
    randomize_elems();
    det_in = 8'h5A;
    stream(25, -1, 1'b0);
    wait_result(8'h5A, 1'b0);
    check("err_cleared", {199'd0, err}, 200'd0);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
